// File: rtl/gpu_instr_queue_pkg.sv
// Purpose : shared GPU definitions for the Nios-to-GPU instruction queue.
// Contents: instruction word field positions, status register bit indices and
//           the opcode enumeration.
package gpu_instr_queue_pkg;

   // Instruction word layout as written by the CPU PIO: [31] toggle, [30:27] opcode, [26:0] operand
   localparam int TOGGLE_BIT    = 31;
   localparam int OPCODE_MSB    = 30;
   localparam int OPCODE_LSB    = 27;
   localparam int OPCODE_WIDTH  = OPCODE_MSB - OPCODE_LSB + 1;
   localparam int OPERAND_WIDTH = 27;
   localparam int ENTRY_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;

   // Status register bit indices
   localparam int STAT_LEVEL_MSB = 4;
   localparam int STAT_LEVEL_LSB = 0;
   localparam int STAT_OVERFLOW  = 8;
   localparam int STAT_FULL      = 9;
   localparam int STAT_EMPTY     = 10;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_NOP        = 4'h0,
      OP_SET_REG    = 4'h1,
      OP_DRAW_PIXEL = 4'h2,
      OP_DRAW_LINE  = 4'h3,
      OP_FILL_RECT  = 4'h4,
      OP_BLIT       = 4'h5,
      OP_SWAP_BUF   = 4'h6,
      OP_FENCE      = 4'h7
   } gpu_opcode_e;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Purpose : single-clock FIFO, DEPTH (power of two) entries of WIDTH bits.
// Latency : a push at edge N is visible on rd_data after edge N.
// Backpr. : push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
// Ports   : clk, reset_n, push/wr_data, pop/rd_data, level (0..DEPTH), full, empty.
module gpu_sync_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign do_push = push && (!full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LVL_W'(1);
            2'b01:   cnt <= cnt - LVL_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; stale contents are hidden by the empty gate below
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];
   assign level   = cnt;

endmodule

// File: rtl/gpu_instr_queue.sv
// Purpose : captures toggle-flagged instruction words from the CPU PIO and queues them for the GPU.
// Latency : one cycle from a detected toggle into an empty queue to cmd_valid.
// Backpr. : cmd_valid/cmd_ready handshake on the GPU side; words arriving while full are dropped and flag overflow.
// Ports   : clk, reset_n, instr_port (PIO word), clr_overflow (pulse), cmd_valid/cmd_ready/cmd_opcode/cmd_operand, status.
module gpu_instr_queue
   import gpu_instr_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              instr_port,
   input  logic                     clr_overflow,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [OPCODE_WIDTH-1:0]  cmd_opcode,
   output logic [OPERAND_WIDTH-1:0] cmd_operand,
   output logic [31:0]              status
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                   last_toggle;
   logic                   overflow;
   logic                   detect;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic                   full;
   logic                   empty;
   logic [LVL_W-1:0]       level;
   logic [ENTRY_WIDTH-1:0] head;

   // A new word is flagged by the CPU flipping bit 31
   assign detect = (instr_port[TOGGLE_BIT] != last_toggle);
   assign pop    = cmd_valid && cmd_ready;
   assign push   = detect && (!full || pop);
   assign drop   = detect && full && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_toggle <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (detect) last_toggle <= instr_port[TOGGLE_BIT];
         // A fresh drop wins over a coincident clear so the event is never lost
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   gpu_sync_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wr_data (instr_port[OPCODE_MSB:0]),
      .pop     (pop),
      .rd_data (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   // Outputs come only from registered FIFO state, never from instr_port directly
   assign cmd_valid   = !empty;
   assign cmd_opcode  = head[ENTRY_WIDTH-1:OPERAND_WIDTH];
   assign cmd_operand = head[OPERAND_WIDTH-1:0];

   always_comb begin
      status                                = '0;
      status[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 5'(level);
      status[STAT_OVERFLOW]                 = overflow;
      status[STAT_FULL]                     = full;
      status[STAT_EMPTY]                    = empty;
   end

endmodule

// File: tb/tb_gpu_instr_queue.sv
module tb_gpu_instr_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] instr_port = '0;
   logic        clr_overflow = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [3:0]  cmd_opcode;
   logic [26:0] cmd_operand;
   logic [31:0] status;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Reference model: a queue of {opcode, operand} words plus toggle and overflow state
   logic [30:0] mq[$];
   logic        m_tog;
   logic        m_ovf;

   gpu_instr_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .instr_port   (instr_port),
      .clr_overflow (clr_overflow),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_operand  (cmd_operand),
      .status       (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_tog = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] exp_status;
      logic [30:0] hd;
      int          n;
      n  = mq.size();
      hd = (n != 0) ? mq[0] : 31'd0;
      exp_status = 32'(n);
      exp_status[8]  = m_ovf;
      exp_status[9]  = (n == DEPTH);
      exp_status[10] = (n == 0);
      check({tag, ".valid"},   32'(cmd_valid),   32'(n != 0));
      check({tag, ".opcode"},  32'(cmd_opcode),  32'(hd[30:27]));
      check({tag, ".operand"}, 32'(cmd_operand), 32'(hd[26:0]));
      check({tag, ".status"},  status,           exp_status);
   endtask

   // Apply one cycle of inputs, advance the model by the queue's rules, then compare
   task automatic step(input string tag, input logic [31:0] instr, input logic rdy, input logic clr);
      logic det, pp, fl;
      instr_port   = instr;
      cmd_ready    = rdy;
      clr_overflow = clr;
      det = (instr[31] != m_tog);
      pp  = (mq.size() != 0) && rdy;
      fl  = (mq.size() == DEPTH);
      if (det && fl && !pp) m_ovf = 1'b1;
      else if (clr)         m_ovf = 1'b0;
      if (det) m_tog = instr[31];
      if (pp)  void'(mq.pop_front());
      if (det && (!fl || pp)) mq.push_back(instr[30:0]);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   logic [31:0] w;
   logic [31:0] cur;
   logic [31:0] r;
   logic        t;

   initial begin
      model_reset();
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid",   32'(cmd_valid),   32'd0);
      check("rst.opcode",  32'(cmd_opcode),  32'd0);
      check("rst.operand", 32'(cmd_operand), 32'd0);
      check("rst.status",  status,           32'h0000_0400);
      @(negedge clk);
      reset_n = 1'b1;

      // First word after reset: toggle=1, opcode 0, operand 5
      step("first", 32'h8000_0005, 1'b0, 1'b0);
      check("first.valid",   32'(cmd_valid),   32'd1);
      check("first.operand", 32'(cmd_operand), 32'd5);
      check("first.status",  status,           32'h0000_0001);

      // Holding the word steady must not push again
      for (int i = 0; i < 20; i++) step("hold", 32'h8000_0005, 1'b0, 1'b0);
      check("hold.level", status, 32'h0000_0001);

      // Eight more toggled writes with no drain: last one overflows
      cur = 32'h8000_0005;
      for (int k = 1; k <= 8; k++) begin
         w = {~cur[31], 4'(k), 27'(k * 1000 + 7)};
         cur = w;
         step("fill", w, 1'b0, 1'b0);
      end
      check("ovf.status", status, 32'h0000_0308);
      step("clr", cur, 1'b0, 1'b1);
      check("clr.status", status, 32'h0000_0208);

      // Full queue, detection with coincident pop: stored, no overflow
      w = {~cur[31], 4'h7, 27'h5A5A5A5};
      cur = w;
      step("fullpop", w, 1'b1, 1'b0);
      check("fullpop.status", status, 32'h0000_0208);
      for (int i = 0; i < 7; i++) step("drain", cur, 1'b1, 1'b0);
      check("lastout.opcode",  32'(cmd_opcode),  32'h7);
      check("lastout.operand", 32'(cmd_operand), 32'h5A5A5A5);
      step("drain", cur, 1'b1, 1'b0);
      check("drained.status", status, 32'h0000_0400);

      // Random traffic: toggles, random ready and occasional overflow clears
      t = cur[31];
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         if ($urandom_range(1, 0) == 1) t = ~t;
         step("rand", {t, r[30:0]}, 1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0));
      end
      for (int i = 0; i < DEPTH + 1; i++) step("flush", {t, 31'd0}, 1'b1, 1'b1);

      // Mid-handshake asynchronous reset with three entries queued
      for (int k = 0; k < 3; k++) begin
         t = ~t;
         step("pre", {t, 4'(k), 27'(k + 100)}, 1'b0, 1'b0);
      end
      check("pre.status", status, 32'h0000_0003);
      cmd_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst.valid",  32'(cmd_valid), 32'd0);
      check("arst.status", status,         32'h0000_0400);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      // Toggle register cleared: bit31=0 is not new, bit31=1 is
      step("post0", 32'h0123_4567, 1'b0, 1'b0);
      step("post1", 32'h8765_4321, 1'b0, 1'b0);
      check("post1.status", status, 32'h0000_0001);

      cmd_ready = 1'b0;
      clr_overflow = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gpu_instr_queue.md
GPU_INSTR_QUEUE -- requirements
Module: gpu_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port instr_port, input, 32, instruction word from the Nios PIO out_port: [31] toggle, [30:27] opcode, [26:0] operand.
REQ-005 SHALL have port clr_overflow, input, 1, single-cycle pulse that clears the sticky overflow flag.
REQ-006 SHALL have port cmd_valid, output, 1, head entry available to the GPU.
REQ-007 SHALL have port cmd_ready, input, 1, GPU accepts the head entry when high with cmd_valid.
REQ-008 SHALL have port cmd_opcode, output, 4, head entry opcode.
REQ-009 SHALL have port cmd_operand, output, 27, head entry operand.
REQ-010 SHALL have port status, output, 32, CPU-readable status: [4:0] level, [8] overflow, [9] full, [10] empty, all other bits 0.

Function
REQ-011 SHALL hold register last_toggle; a new instruction is detected on any clock edge where instr_port[31] != last_toggle.
REQ-012 SHALL copy instr_port[31] into last_toggle on every detection, whether or not the word is stored.
REQ-013 SHALL push {opcode, operand} on detection when not full, or when full and a pop occurs in the same cycle.
REQ-014 SHALL drop the word on detection when full with no same-cycle pop, and SHALL set overflow.
REQ-015 SHALL pop on a clock edge where cmd_valid && cmd_ready; cmd_ready while empty has no effect.
REQ-016 SHALL apply a simultaneous push and pop with level unchanged and both pointers advanced.
REQ-017 SHALL drive cmd_valid = (level != 0); cmd_opcode/cmd_operand SHALL show the oldest entry and stay stable while cmd_valid && !cmd_ready.
REQ-018 SHALL give a latency of 1 cycle: a detection at edge N into an empty FIFO gives cmd_valid high after edge N.
REQ-019 SHALL wrap read and write pointers modulo DEPTH; level SHALL range 0..DEPTH.
REQ-020 SHALL define full as level == DEPTH and empty as level == 0.
REQ-021 SHALL keep overflow sticky until clr_overflow; if clr_overflow and a new overflow occur in the same cycle, overflow SHALL end up 1.
REQ-022 SHALL produce no combinational path from instr_port to any output.

Reset
REQ-023 SHALL asynchronously clear last_toggle, pointers, level and overflow while reset_n is 0.
REQ-024 SHALL hold outputs at reset: cmd_valid 0, cmd_opcode 0, cmd_operand 0, status 0x00000400 (empty=1).
REQ-025 SHALL discard in-flight entries when reset is asserted mid-operation; the first detection after release SHALL be instr_port[31] == 1.
REQ-026 SHALL need no reset on the FIFO storage array; outputs are gated to 0 while empty.

Structure
REQ-027 SHALL place in the shared gpu package: field position constants (TOGGLE_BIT=31, OPCODE_MSB/LSB=30/27, OPERAND_WIDTH=27), status bit indices and the opcode enumeration type.
REQ-028 SHALL use one sub-module, gpu_sync_fifo (parameterised width/depth, push/pop/level/full/empty); edge detection, overflow and status stay in the top.

Verification
REQ-029 SHALL cover: after reset, set instr_port=0x8000_0005 -> one cycle later cmd_valid=1, opcode=0, operand=5, status level=1.
REQ-030 SHALL cover: hold instr_port constant 20 cycles after one detection -> exactly one entry pushed.
REQ-031 SHALL cover: 9 toggled writes with cmd_ready=0, DEPTH=8 -> level=8, full=1, overflow=1, 9th word absent; then clr_overflow -> overflow=0.
REQ-032 SHALL cover: FIFO full, detection coincident with cmd_ready=1 -> level stays 8, overflow stays 0, new word is last out.
REQ-033 SHALL cover: 20 writes drained at random cmd_ready -> output order equals write order across pointer wrap.
REQ-034 SHALL cover: reset_n pulsed low with level=3 mid-handshake -> cmd_valid=0 immediately, status=0x400, last_toggle=0.
